// File: rtl/alu_uart_sequencer.sv
// Frame sequencer: RX bytes -> opcode + two LE 16-bit operands -> adder -> sum/flags bytes on TX.
// Optional inter-byte timeout is compiled in with `define SEQ_TIMEOUT_EN.
module alu_uart_sequencer #(
    parameter int N = 16
`ifdef SEQ_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 100000
`endif
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [7:0]   rx_data_i,
    input  logic         rx_valid_i,
    output logic [7:0]   tx_data_o,
    output logic         tx_valid_o,
    input  logic         tx_ready_i,
    output logic [N-1:0] add_a_o,
    output logic [N-1:0] add_b_o,
    input  logic [N-1:0] add_sum_i,
    input  logic [3:0]   add_flags_i,
    output logic         busy_o,
    output logic         overrun_o
);

    // IDLE opcode wait | A_LO..B_HI operand bytes | EXEC capture sum | TX_LO/TX_HI/TX_FLG result bytes | TX_ERR error code
    typedef enum logic [3:0] {
        S_IDLE, S_A_LO, S_A_HI, S_B_LO, S_B_HI,
        S_EXEC, S_TX_LO, S_TX_HI, S_TX_FLG, S_TX_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] add_a_q, add_a_d, add_b_q, add_b_d;
    logic [7:0]  res_hi_q, res_hi_d;
    logic [3:0]  flg_q, flg_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        overrun_q, overrun_d;
    logic        tx_hs;

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    assign tx_hs = tx_valid_q & tx_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            add_a_q    <= '0;
            add_b_q    <= '0;
            res_hi_q   <= '0;
            flg_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            tmo_q      <= TMO_LOAD;
`endif
        end else begin
            state_q    <= state_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            res_hi_q   <= res_hi_d;
            flg_q      <= flg_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            overrun_q  <= overrun_d;
`ifdef SEQ_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        res_hi_d   = res_hi_q;
        flg_d      = flg_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        overrun_d  = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (rx_valid_i) begin
                    if (rx_data_i == 8'h01) begin
                        state_d = S_A_LO;
                    end else begin
                        state_d    = S_TX_ERR;
                        tx_data_d  = 8'hEE;
                        tx_valid_d = 1'b1;
                    end
                end
            end
            S_A_LO: if (rx_valid_i) begin add_a_d[7:0]  = rx_data_i; state_d = S_A_HI; end
            S_A_HI: if (rx_valid_i) begin add_a_d[15:8] = rx_data_i; state_d = S_B_LO; end
            S_B_LO: if (rx_valid_i) begin add_b_d[7:0]  = rx_data_i; state_d = S_B_HI; end
            S_B_HI: if (rx_valid_i) begin add_b_d[15:8] = rx_data_i; state_d = S_EXEC; end
            S_EXEC: begin
                res_hi_d   = add_sum_i[15:8];
                flg_d      = add_flags_i;
                tx_data_d  = add_sum_i[7:0];
                tx_valid_d = 1'b1;
                state_d    = S_TX_LO;
            end
            S_TX_LO: if (tx_hs) begin tx_data_d = res_hi_q;        state_d = S_TX_HI;  end
            S_TX_HI: if (tx_hs) begin tx_data_d = {4'b0000, flg_q}; state_d = S_TX_FLG; end
            S_TX_FLG, S_TX_ERR: begin
                if (tx_hs) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // RX cannot stall, so anything arriving while the result is in flight is lost
        if (rx_valid_i && (state_q inside {S_EXEC, S_TX_LO, S_TX_HI, S_TX_FLG, S_TX_ERR}))
            overrun_d = 1'b1;

`ifdef SEQ_TIMEOUT_EN
        tmo_d = TMO_LOAD;
        if ((state_q inside {S_A_LO, S_A_HI, S_B_LO, S_B_HI}) && !rx_valid_i) begin
            if (tmo_q == '0) begin
                state_d    = S_TX_ERR;
                tx_data_d  = 8'hEF;
                tx_valid_d = 1'b1;
            end else begin
                tmo_d = tmo_q - TW'(1);
            end
        end
`endif
    end

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign add_a_o    = add_a_q;
    assign add_b_o    = add_b_q;
    assign busy_o     = (state_q != S_IDLE);
    assign overrun_o  = overrun_q;

endmodule
